// File: rtl/divu_sequencer_pkg.sv
// Shared definitions for the DIVU/MFLO/MFHI sequencer.
// Contents:
//   FUNCT_DIVU / FUNCT_MFLO / FUNCT_MFHI : R-type funct codes served by the unit
//   state_t                              : sequencer state encoding
package divu_sequencer_pkg;

  localparam logic [5:0] FUNCT_DIVU = 6'h1B;
  localparam logic [5:0] FUNCT_MFLO = 6'h12;
  localparam logic [5:0] FUNCT_MFHI = 6'h10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/divu_sequencer_div_step.sv
// One restoring-division iteration, purely combinational.
// Ports:
//   rem      in  WIDTH  partial remainder
//   quo      in  WIDTH  dividend bits still to shift in / quotient bits so far
//   dvs      in  WIDTH  divisor
//   rem_next out WIDTH  partial remainder after this iteration
//   quo_next out WIDTH  quotient register after this iteration
module divu_sequencer_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // The shifted remainder is kept WIDTH+1 bits wide so the compare cannot
  // overflow; the subtract only needs the low WIDTH bits because a taken
  // subtraction always leaves a result smaller than the divisor.
  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] t_sub;
  logic             ge;

  assign t        = {rem, quo[WIDTH-1]};
  assign ge       = (t >= {1'b0, dvs});
  assign t_sub    = t[WIDTH-1:0] - dvs;
  assign rem_next = ge ? t_sub : t[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ge};

endmodule

// File: rtl/divu_sequencer.sv
// Multi-cycle unsigned divider with architectural HI/LO registers.
// Executes DIVU one quotient bit per cycle and answers MFLO/MFHI reads,
// stalling HI/LO-related instructions while a divide is running.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   issue                instruction valid and leaving decode unless stalled
//   op_divu/mflo/mfhi    one-hot decoded strobes (priority divu > mflo > mfhi)
//   dividend, divisor    rs / rt operands, sampled only at acceptance
//   stall                combinational pipeline hold request
//   busy                 divide in progress
//   div_zero             last completed DIVU had a zero divisor
//   hilo_rdata           LO for MFLO, HI for MFHI, otherwise 0
//   lo, hi               architectural LO / HI registers
module divu_sequencer
  import divu_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue,
  input  logic             op_divu,
  input  logic             op_mflo,
  input  logic             op_mfhi,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             stall,
  output logic             busy,
  output logic             div_zero,
  output logic [WIDTH-1:0] hilo_rdata,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic [WIDTH-1:0] rem_next, quo_next;
  logic             accept;
  logic             divisor_zero;
  logic             last_step;

  assign accept       = issue & op_divu & (state == ST_IDLE);
  assign divisor_zero = (divisor == '0);
  assign last_step    = (cnt == CNT_W'(1));
  assign busy         = (state == ST_RUN);
  assign stall        = issue & (op_divu | op_mflo | op_mfhi) & (state == ST_RUN);

  divu_sequencer_div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem      (rem),
    .quo      (quo),
    .dvs      (dvs),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A zero divisor is resolved on the acceptance edge, so only a real
  // divide enters RUN.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept && !divisor_zero) state_next = ST_RUN;
      ST_RUN:  if (last_step) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: operands are captured only at acceptance; the final iteration
  // writes straight into HI/LO so the result is visible the cycle after busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else if (accept) begin
      if (divisor_zero) begin
        hi       <= dividend;
        lo       <= '1;
        div_zero <= 1'b1;
      end else begin
        rem <= '0;
        quo <= dividend;
        dvs <= divisor;
        cnt <= CNT_W'(WIDTH);
      end
    end else if (state == ST_RUN) begin
      rem <= rem_next;
      quo <= quo_next;
      cnt <= cnt - CNT_W'(1);
      if (last_step) begin
        hi       <= rem_next;
        lo       <= quo_next;
        div_zero <= 1'b0;
      end
    end
  end

  // Read mux follows the decode priority so a conflicting DIVU wins.
  always_comb begin
    hilo_rdata = '0;
    if (op_divu) begin
      hilo_rdata = '0;
    end else if (op_mflo) begin
      hilo_rdata = lo;
    end else if (op_mfhi) begin
      hilo_rdata = hi;
    end
  end

endmodule

// File: tb/tb_divu_sequencer.sv
// Self-checking bench for divu_sequencer: directed scenarios plus randomized
// instruction streams, checked every cycle against an arithmetic model.
module tb_divu_sequencer;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             issue;
  logic             op_divu, op_mflo, op_mfhi;
  logic [WIDTH-1:0] dividend, divisor;
  logic             stall, busy, div_zero;
  logic [WIDTH-1:0] hilo_rdata, lo, hi;

  int checks = 0;
  int errors = 0;

  // Reference model state: architectural registers plus the number of
  // busy cycles left and the pending result of the running divide.
  logic [WIDTH-1:0] m_hi, m_lo, m_q, m_r;
  logic             m_dz;
  int               m_busy_left;

  divu_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue      (issue),
    .op_divu    (op_divu),
    .op_mflo    (op_mflo),
    .op_mfhi    (op_mfhi),
    .dividend   (dividend),
    .divisor    (divisor),
    .stall      (stall),
    .busy       (busy),
    .div_zero   (div_zero),
    .hilo_rdata (hilo_rdata),
    .lo         (lo),
    .hi         (hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_hi = '0; m_lo = '0; m_q = '0; m_r = '0; m_dz = 1'b0; m_busy_left = 0;
  endtask

  task automatic checkCycle();
    logic             exp_busy, exp_stall;
    logic [WIDTH-1:0] exp_rd;
    exp_busy  = (m_busy_left > 0);
    exp_stall = issue & (op_divu | op_mflo | op_mfhi) & exp_busy;
    if (op_divu)      exp_rd = '0;
    else if (op_mflo) exp_rd = m_lo;
    else if (op_mfhi) exp_rd = m_hi;
    else              exp_rd = '0;
    checkOutput("busy",       WIDTH'(busy),     WIDTH'(exp_busy));
    checkOutput("stall",      WIDTH'(stall),    WIDTH'(exp_stall));
    checkOutput("div_zero",   WIDTH'(div_zero), WIDTH'(m_dz));
    checkOutput("hi",         hi,               m_hi);
    checkOutput("lo",         lo,               m_lo);
    checkOutput("hilo_rdata", hilo_rdata,       exp_rd);
  endtask

  // Model of one rising edge, written from the instruction-level rules.
  task automatic modelEdge();
    if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) begin
        m_hi = m_r; m_lo = m_q; m_dz = 1'b0;
      end
    end else if (issue && op_divu) begin
      if (divisor == '0) begin
        m_hi = dividend; m_lo = '1; m_dz = 1'b1;
      end else begin
        m_q = dividend / divisor;
        m_r = dividend % divisor;
        m_busy_left = WIDTH;
      end
    end
  endtask

  // Drive one cycle of inputs, check at the falling edge, advance the model.
  task automatic applyStimulus(input logic iss, input logic dv, input logic ml,
                               input logic mh, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b);
    issue = iss; op_divu = dv; op_mflo = ml; op_mfhi = mh;
    dividend = a; divisor = b;
    @(negedge clk);
    checkCycle();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic runDivide(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, a, b);
    idleCycles(WIDTH);
  endtask

  initial begin
    int kind;
    int sel;
    logic [WIDTH-1:0] ra, rb;

    rst_n = 1'b0; issue = 1'b0; op_divu = 1'b0; op_mflo = 1'b0; op_mfhi = 1'b0;
    dividend = '0; divisor = '0;
    modelReset();
    #1;
    checkOutput("reset_busy", WIDTH'(busy), '0);
    checkOutput("reset_hi",   hi,           '0);
    checkOutput("reset_lo",   lo,           '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 100 / 7 with MFLO held in decode until the divide finishes.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
    for (int i = 0; i < WIDTH; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
    checkOutput("lo_100_7", lo, 32'd14);
    checkOutput("hi_100_7", hi, 32'd2);

    // Width extremes.
    runDivide(32'hFFFF_FFFF, 32'd1);
    checkOutput("lo_max_1", lo, 32'hFFFF_FFFF);
    checkOutput("hi_max_1", hi, 32'd0);
    runDivide(32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("lo_msb_max", lo, 32'd0);
    checkOutput("hi_msb_max", hi, 32'h8000_0000);

    // Divide by zero resolves on the acceptance edge.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd1234, 32'd0);
    checkOutput("dz_hi",   hi,               32'd1234);
    checkOutput("dz_lo",   lo,               32'hFFFF_FFFF);
    checkOutput("dz_flag", WIDTH'(div_zero), 32'd1);
    checkOutput("dz_busy", WIDTH'(busy),     32'd0);
    runDivide(32'd9, 32'd3);
    checkOutput("lo_9_3",  lo,               32'd3);
    checkOutput("dz_clr",  WIDTH'(div_zero), 32'd0);

    // Back-to-back DIVU: the second is held, then independent work overlaps.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd50, 32'd5);
    for (int i = 0; i <= WIDTH; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd7, 32'd2);
    for (int i = 0; i < WIDTH; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    checkOutput("lo_7_2", lo, 32'd3);
    checkOutput("hi_7_2", hi, 32'd1);

    // Reset in the middle of a divide.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd1000, 32'd3);
    idleCycles(10);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", WIDTH'(busy), '0);
    checkOutput("abort_hi",   hi,           '0);
    checkOutput("abort_lo",   lo,           '0);
    modelReset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    runDivide(32'd1000, 32'd3);
    checkOutput("lo_1000_3", lo, 32'd333);
    checkOutput("hi_1000_3", hi, 32'd1);

    // Operand inputs wander during RUN.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd77, 32'd8);
    for (int i = 0; i < WIDTH; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, $urandom, $urandom);
    checkOutput("lo_77_8", lo, 32'd9);
    checkOutput("hi_77_8", hi, 32'd5);

    // Random instruction stream.
    for (int i = 0; i < 600; i++) begin
      kind = $urandom_range(0, 3);
      sel  = $urandom_range(0, 7);
      ra   = $urandom;
      if (sel == 0)      rb = '0;
      else if (sel < 4)  rb = WIDTH'($urandom_range(1, 255));
      else               rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(0, 31);
      applyStimulus($urandom_range(0, 3) != 0, kind == 0, kind == 1, kind == 2, ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
